// File: rtl/arith_seq_ctrl.sv
// Sequencing controller for the calculator's arithmetic path: add, subtract or
// shift-add multiply of signed W-bit operands, with registered result/overflow.
module arith_seq_ctrl #(
    parameter int W      = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ad,
    input  logic         su,
    input  logic         mu,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    output logic [W-1:0] res,
    output logic         v,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [2:0]   dbg_state_o
);

    // Handshake: a request level is accepted only while IDLE; done is a one-cycle
    // valid qualifying res/v, with no back-pressure. busy covers LOAD..SETTLE.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_EXEC   = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t state_q, state_d;
    op_t    op_q, op_d;

    logic [W-1:0]   x_q, y_q;
    logic           sy_q, sgn_q;
    logic [2*W-1:0] mcand_q, acc_q;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   pres_q;
    logic           pv_q;
    logic [W-1:0]   res_q;
    logic           v_q, busy_q, done_q, err_q;
    logic           busy_d, done_d, err_d;

    logic [1:0]     n_req;
    logic           illegal_req, legal_req;
    logic [W-1:0]   sum, x_mag, y_mag;
    logic           as_v, mul_v;
    logic [2*W-1:0] acc_nxt, prod;

    assign n_req       = 2'(ad) + 2'(su) + 2'(mu);
    assign illegal_req = (n_req > 2'd1) || (mu && !MUL_EN);
    assign legal_req   = (n_req == 2'd1) && !illegal_req;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (legal_req) begin
                    state_d = S_LOAD;
                    op_d    = ad ? OP_ADD : (su ? OP_SUB : OP_MUL);
                end
            end
            S_LOAD:   state_d = S_EXEC;
            S_EXEC: begin
                if (op_q != OP_MUL || cnt_q == CNT_LAST) state_d = S_SETTLE;
            end
            S_SETTLE: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == S_LOAD) || (state_d == S_EXEC) || (state_d == S_SETTLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_q == S_IDLE) && illegal_req;
    end

    // y_q already holds -y for subtract; overflow uses the original y sign so
    // that y = -2^(W-1), whose negation is itself, is still judged correctly.
    always_comb begin
        sum  = x_q + y_q;
        as_v = 1'b0;
        if (op_q == OP_ADD) as_v = (x_q[W-1] == sy_q) && (sum[W-1] != x_q[W-1]);
        else                as_v = (x_q[W-1] != sy_q) && (sum[W-1] != x_q[W-1]);
    end

    always_comb begin
        x_mag   = x_in[W-1] ? (~x_in + 1'b1) : x_in;
        y_mag   = y_in[W-1] ? (~y_in + 1'b1) : y_in;
        acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod    = sgn_q ? (~acc_nxt + 1'b1) : acc_nxt;
        // The product fits the result iff its top W+1 bits are all sign copies.
        mul_v   = !((&prod[2*W-1:W-1]) || ~(|prod[2*W-1:W-1]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            sy_q     <= 1'b0;
            sgn_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            pres_q   <= '0;
            pv_q     <= 1'b0;
            res_q    <= '0;
            v_q      <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    x_q      <= x_in;
                    y_q      <= (op_q == OP_SUB) ? (~y_in + 1'b1) : y_in;
                    sy_q     <= y_in[W-1];
                    sgn_q    <= x_in[W-1] ^ y_in[W-1];
                    mcand_q  <= {{W{1'b0}}, x_mag};
                    mplier_q <= y_mag;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end
                S_EXEC: begin
                    if (op_q == OP_MUL) begin
                        acc_q    <= acc_nxt;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            pres_q <= prod[W-1:0];
                            pv_q   <= mul_v;
                        end
                    end else begin
                        pres_q <= sum;
                        pv_q   <= as_v;
                    end
                end
                S_SETTLE: begin
                    res_q <= pres_q;
                    v_q   <= pv_q;
                end
                default: ;
            endcase
        end
    end

    assign res         = res_q;
    assign v           = v_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Directed bench for arith_seq_ctrl: done-driven scoreboard plus direct checks
// of err pulses, busy length, reset behaviour and the MUL_EN=0 variant.
module tb_arith_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         ad, su, mu;
    logic [W-1:0] x_in, y_in;
    logic [W-1:0] res;
    logic         v, busy, done, err;
    logic [2:0]   dbg_state;

    logic         ad1, su1, mu1;
    logic [W-1:0] res1;
    logic         v1, busy1, done1, err1;
    logic [2:0]   dbg_state1;

    typedef struct {
        logic [W-1:0] res;
        logic         v;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arith_seq_ctrl #(.W(W), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .ad(ad), .su(su), .mu(mu),
        .x_in(x_in), .y_in(y_in), .res(res), .v(v), .busy(busy),
        .done(done), .err(err), .dbg_state_o(dbg_state)
    );

    arith_seq_ctrl #(.W(W), .MUL_EN(1'b0)) u_nomul (
        .clk(clk), .rst(rst), .ad(ad1), .su(su1), .mu(mu1),
        .x_in(x_in), .y_in(y_in), .res(res1), .v(v1), .busy(busy1),
        .done(done1), .err(err1), .dbg_state_o(dbg_state1)
    );

    // Monitor: every done pulse pops one expected {res, v, cycle}.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got res=%h v=%b at cycle %0d, none expected", res, v, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (res !== e.res || v !== e.v || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL done_check: got res=%h v=%b cyc=%0d, required res=%h v=%b cyc=%0d",
                             res, v, cyc, e.res, e.v, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // op: 0 add, 1 sub, 2 mul. Expected values are supplied by the caller.
    task automatic do_op(input int op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eres, input logic ev);
        int lat, ebusy, bcnt;
        bit seen;
        lat   = (op == 2) ? W + 2 : 3;
        ebusy = (op == 2) ? W + 2 : 3;
        @(negedge clk);
        x_in = x; y_in = y;
        ad = (op == 0); su = (op == 1); mu = (op == 2);
        exp_q.push_back('{eres, ev, cyc + 1 + lat});
        @(posedge clk);
        @(negedge clk);
        ad = 1'b0; su = 1'b0; mu = 1'b0;
        bcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (busy) bcnt++;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_cycles", bcnt, ebusy);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ad = 0; su = 0; mu = 0; ad1 = 0; su1 = 0; mu1 = 0;
        x_in = '0; y_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res", res, 0);
        chk("rst_flags", {v, busy, done, err}, 0);
        chk("rst_state", dbg_state, 0);
        rst = 1'b0;

        do_op(0, 8'd100, 8'd50, 8'h96, 1'b1);
        do_op(1, 8'd5,   8'd7,  8'hFE, 1'b0);
        do_op(1, 8'h80,  8'd1,  8'h7F, 1'b1);
        do_op(1, 8'd0,   8'h80, 8'h80, 1'b1);
        do_op(2, 8'd16,  8'd8,  8'h80, 1'b1);
        do_op(2, 8'hF0,  8'd8,  8'h80, 1'b0);
        do_op(2, 8'hFD,  8'hFB, 8'h0F, 1'b0);

        // Illegal ad+su: err pulses each cycle held, res/v untouched.
        @(negedge clk);
        ad = 1'b1; su = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ill_err", err, 1);
        chk("ill_busy", busy, 0);
        chk("ill_res", res, 8'h0F);
        chk("ill_v", v, 0);
        @(posedge clk); @(negedge clk);
        chk("ill_err_held", err, 1);
        ad = 1'b0; su = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ill_err_clear", err, 0);
        chk("ill_state", dbg_state, 0);
        chk("ill_res_after", res, 8'h0F);

        // Multiply on the MUL_EN=0 instance is illegal.
        mu1 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("nomul_err", err1, 1);
        chk("nomul_busy", busy1, 0);
        mu1 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("nomul_err_clear", err1, 0);
        chk("nomul_state", dbg_state1, 0);

        // Held add: done every 5 cycles; su toggled only while busy.
        @(negedge clk);
        x_in = 8'd3; y_in = 8'd4; ad = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back('{8'h07, 1'b0, cyc + 4 + 5 * k});
        for (int j = 0; j < 15; j++) begin
            @(posedge clk); @(negedge clk);
            su = ((j % 5) == 0) || ((j % 5) == 2);
            if (j == 14) ad = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Reset during multiply EXEC aborts the op.
        x_in = 8'd16; y_in = 8'd8; mu = 1'b1;
        @(posedge clk); @(negedge clk);
        mu = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("pre_rst_state", dbg_state, 2);
        rst = 1'b1;
        #1;
        chk("arst_res", res, 0);
        chk("arst_flags", {v, busy, done, err}, 0);
        chk("arst_state", dbg_state, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        do_op(0, 8'd1, 8'd1, 8'h02, 1'b0);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got no finish, required finish before 50000");
        $fatal(1);
    end

endmodule
